// File: rtl/bp_me_stream_pump_out_if.sv
// Producer-FSM beat channel and BedRock stream output channels of the outbound stream pump.
interface bp_me_stream_pump_out_if #(
    parameter int paddr_width_p       = 40,
    parameter int stream_data_width_p = 64,
    parameter int payload_width_p     = 16,
    parameter int cnt_width_p         = 3
);
    localparam int hdr_width_lp = 7 + paddr_width_p + payload_width_p;

    logic [hdr_width_lp-1:0]        fsm_base_header_i;
    logic [stream_data_width_p-1:0] fsm_data_i;
    logic                           fsm_v_i;
    logic                           fsm_ready_and_o;
    logic [paddr_width_p-1:0]       fsm_addr_o;
    logic [cnt_width_p-1:0]         fsm_cnt_o;
    logic                           fsm_new_o;
    logic                           fsm_last_o;

    logic [hdr_width_lp-1:0]        msg_header_o;
    logic                           msg_has_data_o;
    logic                           msg_header_v_o;
    logic                           msg_header_ready_and_i;
    logic [stream_data_width_p-1:0] msg_data_o;
    logic                           msg_data_v_o;
    logic                           msg_data_ready_and_i;
    logic                           msg_last_o;

    modport master (
        output fsm_base_header_i, fsm_data_i, fsm_v_i, msg_header_ready_and_i, msg_data_ready_and_i,
        input  fsm_ready_and_o, fsm_addr_o, fsm_cnt_o, fsm_new_o, fsm_last_o,
        input  msg_header_o, msg_has_data_o, msg_header_v_o, msg_data_o, msg_data_v_o, msg_last_o
    );

    modport slave (
        input  fsm_base_header_i, fsm_data_i, fsm_v_i, msg_header_ready_and_i, msg_data_ready_and_i,
        output fsm_ready_and_o, fsm_addr_o, fsm_cnt_o, fsm_new_o, fsm_last_o,
        output msg_header_o, msg_has_data_o, msg_header_v_o, msg_data_o, msg_data_v_o, msg_last_o
    );
endinterface

// File: rtl/bp_me_stream_pump_out.sv
// Outbound BedRock stream pump: turns producer beats into buffered header/data channels while
// tracking beat index and critical-word-first wraparound address for the producer.
module bp_me_stream_pump_out #(
    parameter int          paddr_width_p       = 40,
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter int          payload_width_p     = 16,
    parameter logic [15:0] msg_stream_mask_p   = 16'h0000,
    parameter logic [15:0] fsm_stream_mask_p   = msg_stream_mask_p,
    parameter logic [15:0] data_type_mask_p    = 16'h002A,
    parameter int          header_els_p        = 2,
    parameter int          data_els_p          = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_me_stream_pump_out_if.slave io
);
    localparam int byte_bits_lp  = $clog2(stream_data_width_p / 8);
    localparam int max_words_lp  = block_width_p / stream_data_width_p;
    localparam int cnt_width_lp  = (max_words_lp > 1) ? $clog2(max_words_lp) : 1;
    localparam int hdr_width_lp  = 7 + paddr_width_p + payload_width_p;
    localparam int hptr_width_lp = (header_els_p > 1) ? $clog2(header_els_p) : 1;
    localparam int dptr_width_lp = (data_els_p > 1) ? $clog2(data_els_p) : 1;
    localparam int hcnt_width_lp = $clog2(header_els_p + 1);
    localparam int dcnt_width_lp = $clog2(data_els_p + 1);

    typedef enum logic {e_ready, e_stream} state_e;

    state_e                  r_state;
    logic [cnt_width_lp-1:0] r_cnt;
    logic [cnt_width_lp-1:0] r_beats;

    // Header layout: {payload, addr, size[2:0], msg_type[3:0]}
    logic [3:0]               w_type;
    logic [2:0]               w_size;
    logic [paddr_width_p-1:0] w_addr;
    assign w_type = io.fsm_base_header_i[3:0];
    assign w_size = io.fsm_base_header_i[6:4];
    assign w_addr = io.fsm_base_header_i[7 +: paddr_width_p];

    logic [31:0] w_words;
    always_comb begin
        w_words = (32'd1 << w_size) >> byte_bits_lp;
        if (w_words == 32'd0) w_words = 32'd1;
        if (w_words > 32'(max_words_lp)) w_words = 32'(max_words_lp);
    end

    logic w_burst, w_msg_stream, w_fsm_stream, w_nn, w_has_data, w_new, w_beat_has_data, w_last;
    logic [cnt_width_lp-1:0]  w_words_m1, w_cnt, w_beats;
    logic [paddr_width_p-1:0] w_win_mask, w_fsm_addr;

    assign w_burst         = (w_size > 3'd3);
    assign w_msg_stream    = msg_stream_mask_p[w_type] & w_burst;
    assign w_fsm_stream    = fsm_stream_mask_p[w_type] & w_burst;
    assign w_nn            = w_msg_stream & w_fsm_stream;
    assign w_has_data      = w_msg_stream | data_type_mask_p[w_type];
    assign w_words_m1      = w_fsm_stream ? cnt_width_lp'(w_words - 32'd1) : '0;
    assign w_new           = (r_state == e_ready);
    // Only N:N messages carry data on every beat; otherwise just the first beat can.
    assign w_beat_has_data = w_nn | (w_has_data & w_new);
    assign w_cnt           = w_new ? (w_addr[byte_bits_lp +: cnt_width_lp] & w_words_m1) : r_cnt;
    assign w_beats         = w_new ? '0 : r_beats;
    assign w_last          = (w_beats == w_words_m1);
    assign w_win_mask      = ((paddr_width_p'(w_words_m1) + paddr_width_p'(1)) << byte_bits_lp)
                             - paddr_width_p'(1);
    assign w_fsm_addr      = (w_words_m1 == '0) ? w_addr
                             : ((w_addr & ~w_win_mask) | (paddr_width_p'(w_cnt) << byte_bits_lp));

    logic [hcnt_width_lp-1:0] r_hdr_cnt;
    logic [dcnt_width_lp-1:0] r_data_cnt;
    logic w_hdr_full, w_data_full, w_ready, w_accept, w_hdr_enq, w_data_enq, w_hdr_deq, w_data_deq;

    assign w_hdr_full  = (r_hdr_cnt == hcnt_width_lp'(header_els_p));
    assign w_data_full = (r_data_cnt == dcnt_width_lp'(data_els_p));
    assign w_ready     = (~w_new | ~w_hdr_full) & (~w_beat_has_data | ~w_data_full);
    assign w_accept    = io.fsm_v_i & w_ready;
    assign w_hdr_enq   = w_accept & w_new;
    assign w_data_enq  = w_accept & w_beat_has_data;
    assign w_hdr_deq   = (r_hdr_cnt != '0) & io.msg_header_ready_and_i;
    assign w_data_deq  = (r_data_cnt != '0) & io.msg_data_ready_and_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_ready;
            r_cnt   <= '0;
            r_beats <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= e_ready;
                r_cnt   <= '0;
                r_beats <= '0;
            end else begin
                r_state <= e_stream;
                r_cnt   <= (w_cnt + cnt_width_lp'(1)) & w_words_m1;
                r_beats <= w_beats + cnt_width_lp'(1);
            end
        end
    end

    // Header buffer entry: {has_data, header}; data buffer entry: {last, data}
    logic [hdr_width_lp:0]        r_hdr_mem  [header_els_p];
    logic [stream_data_width_p:0] r_data_mem [data_els_p];
    logic [hptr_width_lp-1:0]     r_hdr_wptr, r_hdr_rptr;
    logic [dptr_width_lp-1:0]     r_data_wptr, r_data_rptr;

    always_ff @(posedge clk_i) begin
        if (w_hdr_enq)  r_hdr_mem[r_hdr_wptr]   <= {w_has_data, io.fsm_base_header_i};
        if (w_data_enq) r_data_mem[r_data_wptr] <= {(w_nn ? w_last : 1'b1), io.fsm_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hdr_wptr  <= '0;
            r_hdr_rptr  <= '0;
            r_hdr_cnt   <= '0;
            r_data_wptr <= '0;
            r_data_rptr <= '0;
            r_data_cnt  <= '0;
        end else begin
            if (w_hdr_enq)
                r_hdr_wptr <= (r_hdr_wptr == hptr_width_lp'(header_els_p-1)) ? '0 : r_hdr_wptr + hptr_width_lp'(1);
            if (w_hdr_deq)
                r_hdr_rptr <= (r_hdr_rptr == hptr_width_lp'(header_els_p-1)) ? '0 : r_hdr_rptr + hptr_width_lp'(1);
            if (w_data_enq)
                r_data_wptr <= (r_data_wptr == dptr_width_lp'(data_els_p-1)) ? '0 : r_data_wptr + dptr_width_lp'(1);
            if (w_data_deq)
                r_data_rptr <= (r_data_rptr == dptr_width_lp'(data_els_p-1)) ? '0 : r_data_rptr + dptr_width_lp'(1);
            case ({w_hdr_enq, w_hdr_deq})
                2'b10:   r_hdr_cnt <= r_hdr_cnt + hcnt_width_lp'(1);
                2'b01:   r_hdr_cnt <= r_hdr_cnt - hcnt_width_lp'(1);
                default: r_hdr_cnt <= r_hdr_cnt;
            endcase
            case ({w_data_enq, w_data_deq})
                2'b10:   r_data_cnt <= r_data_cnt + dcnt_width_lp'(1);
                2'b01:   r_data_cnt <= r_data_cnt - dcnt_width_lp'(1);
                default: r_data_cnt <= r_data_cnt;
            endcase
        end
    end

    logic [hdr_width_lp:0]        w_hdr_head;
    logic [stream_data_width_p:0] w_data_head;
    assign w_hdr_head  = r_hdr_mem[r_hdr_rptr];
    assign w_data_head = r_data_mem[r_data_rptr];

    assign io.fsm_ready_and_o = w_ready;
    assign io.fsm_addr_o      = w_fsm_addr;
    assign io.fsm_cnt_o       = w_cnt;
    assign io.fsm_new_o       = w_new;
    assign io.fsm_last_o      = w_last;
    assign io.msg_header_o    = w_hdr_head[hdr_width_lp-1:0];
    assign io.msg_has_data_o  = w_hdr_head[hdr_width_lp];
    assign io.msg_header_v_o  = (r_hdr_cnt != '0);
    assign io.msg_data_o      = w_data_head[stream_data_width_p-1:0];
    assign io.msg_last_o      = w_data_head[stream_data_width_p];
    assign io.msg_data_v_o    = (r_data_cnt != '0);

    // The producer must hold its header steady for every beat after the first.
    a_hdr_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (r_state == e_stream) |-> $stable(io.fsm_base_header_i));
endmodule

// File: tb/tb_bp_me_stream_pump_out.sv
// Directed scoreboard bench for the outbound stream pump: SDW=64, 512-bit block, 8-beat bursts.
module tb_bp_me_stream_pump_out;
    localparam int PADDR = 40;
    localparam int SDW   = 64;
    localparam int PAYW  = 16;
    localparam int CNTW  = 3;
    localparam int HDRW  = 7 + PADDR + PAYW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_me_stream_pump_out_if #(
        .paddr_width_p(PADDR), .stream_data_width_p(SDW), .payload_width_p(PAYW), .cnt_width_p(CNTW)
    ) io ();

    bp_me_stream_pump_out #(
        .paddr_width_p(PADDR), .stream_data_width_p(SDW), .block_width_p(512), .payload_width_p(PAYW),
        .msg_stream_mask_p(16'h0002), .fsm_stream_mask_p(16'h0003), .data_type_mask_p(16'h002A),
        .header_els_p(2), .data_els_p(2)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .io(io)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [PADDR+CNTW+1:0] q_fsm  [$];  // {addr, cnt, new, last}
    logic [HDRW:0]         q_hdr  [$];  // {has_data, header}
    logic [SDW:0]          q_data [$];  // {last, data}

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [HDRW-1:0] mk_hdr(input logic [3:0] typ, input logic [2:0] size,
                                               input logic [PADDR-1:0] addr, input logic [PAYW-1:0] pay);
        return {pay, addr, size, typ};
    endfunction

    // Monitor: pops an expectation on every handshake of each channel.
    initial begin : monitor
        logic [PADDR+CNTW+1:0] ef;
        logic [HDRW:0]         eh;
        logic [SDW:0]          ed;
        forever begin
            @(negedge clk);
            if (io.fsm_v_i === 1'b1 && io.fsm_ready_and_o === 1'b1) begin
                $display("fsm  beat addr=%h cnt=%0d new=%0b last=%0b", io.fsm_addr_o, io.fsm_cnt_o,
                         io.fsm_new_o, io.fsm_last_o);
                if (q_fsm.size() == 0) begin
                    n_checks++;
                    $display("FAIL fsm_unexpected: beat accepted, none expected");
                end else begin
                    ef = q_fsm.pop_front();
                    chk("fsm_beat", {io.fsm_addr_o, io.fsm_cnt_o, io.fsm_new_o, io.fsm_last_o}, ef);
                end
            end
            if (io.msg_header_v_o === 1'b1 && io.msg_header_ready_and_i === 1'b1) begin
                $display("hdr  out  has_data=%0b hdr=%h", io.msg_has_data_o, io.msg_header_o);
                if (q_hdr.size() == 0) begin
                    n_checks++;
                    $display("FAIL hdr_unexpected: header %h emitted, none expected", io.msg_header_o);
                end else begin
                    eh = q_hdr.pop_front();
                    chk("msg_header", {io.msg_has_data_o, io.msg_header_o}, eh);
                end
            end
            if (io.msg_data_v_o === 1'b1 && io.msg_data_ready_and_i === 1'b1) begin
                $display("data out  last=%0b data=%h", io.msg_last_o, io.msg_data_o);
                if (q_data.size() == 0) begin
                    n_checks++;
                    $display("FAIL data_unexpected: data %h emitted, none expected", io.msg_data_o);
                end else begin
                    ed = q_data.pop_front();
                    chk("msg_data", {io.msg_last_o, io.msg_data_o}, ed);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [HDRW-1:0] hdr, input logic [SDW-1:0] data);
        int n = 0;
        io.fsm_base_header_i = hdr;
        io.fsm_data_i        = data;
        io.fsm_v_i           = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (io.fsm_ready_and_o !== 1'b1 && n < 200);
        if (io.fsm_ready_and_o !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout: ready=%b after %0d cycles, required 1", io.fsm_ready_and_o, n);
        end
        @(posedge clk);
        #1;
        io.fsm_v_i = 1'b0;
    endtask

    // lo_tbl holds the expected low address byte of each beat, beat 0 in bits [7:0].
    task automatic run_msg(input logic [HDRW-1:0] hdr, input int n_beats, input int n_send,
                           input logic [PADDR-1:0] base, input logic [63:0] lo_tbl,
                           input bit has_data, input bit nn, input bit expect_hdr,
                           input int stall_at, input bit release_hdr, input logic [31:0] tag);
        for (int i = 0; i < n_send; i++) begin
            logic [7:0]      lo;
            logic [CNTW-1:0] cnt;
            logic [SDW-1:0]  d;
            lo  = lo_tbl[8*i +: 8];
            cnt = (n_beats == 1) ? '0 : lo[5:3];
            d   = {tag, 32'(i)};
            if (i == stall_at) begin
                io.fsm_base_header_i = hdr;
                io.fsm_data_i        = d;
                io.fsm_v_i           = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready", 128'(io.fsm_ready_and_o), 128'(0));
                end
                @(posedge clk);
                #1;
                if (release_hdr) io.msg_header_ready_and_i = 1'b1;
                else             io.msg_data_ready_and_i   = 1'b1;
            end
            q_fsm.push_back({base | PADDR'(lo), cnt, (i == 0), (i == n_beats - 1)});
            if (i == 0 && expect_hdr) q_hdr.push_back({has_data, hdr});
            if (nn || (has_data && i == 0)) q_data.push_back({(nn ? (i == n_beats - 1) : 1'b1), d});
            send(hdr, d);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        io.fsm_v_i = 1'b0;
        io.fsm_base_header_i = '0;
        io.fsm_data_i = '0;
        io.msg_header_ready_and_i = 1'b1;
        io.msg_data_ready_and_i = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hdr_v",  128'(io.msg_header_v_o),  128'(0));
        chk("rst_data_v", 128'(io.msg_data_v_o),    128'(0));
        chk("rst_new",    128'(io.fsm_new_o),       128'(1));
        chk("rst_cnt",    128'(io.fsm_cnt_o),       128'(0));
        chk("rst_ready",  128'(io.fsm_ready_and_o), 128'(1));
        idle(1);

        // 1) 64B write N:N, critical word at 0x10
        run_msg(mk_hdr(4'd1, 3'd6, 40'h00_8000_0010, 16'hA1), 8, 8, 40'h00_8000_0000,
                64'h08_00_38_30_28_20_18_10, 1'b1, 1'b1, 1'b1, -1, 1'b0, 32'h1111_0000);
        idle(4);

        // 2) 64B read N:1: eight beats, one header, no data
        run_msg(mk_hdr(4'd0, 3'd6, 40'h00_8000_0040, 16'hB2), 8, 8, 40'h00_8000_0000,
                64'h78_70_68_60_58_50_48_40, 1'b0, 1'b0, 1'b1, -1, 1'b0, 32'h2222_0000);
        idle(4);

        // 3) 8B uncached write 1:1
        run_msg(mk_hdr(4'd3, 3'd3, 40'h00_8000_0108, 16'hC3), 1, 1, 40'h00_8000_0100,
                64'h08, 1'b1, 1'b0, 1'b1, -1, 1'b0, 32'h3333_0000);
        idle(4);

        // 4) data consumer stalled: producer blocks on the third beat
        io.msg_data_ready_and_i = 1'b0;
        run_msg(mk_hdr(4'd1, 3'd6, 40'h00_8000_0200, 16'hD4), 8, 8, 40'h00_8000_0200,
                64'h38_30_28_20_18_10_08_00, 1'b1, 1'b1, 1'b1, 2, 1'b0, 32'h4444_0000);
        idle(4);

        // 5) header consumer stalled: single-beat messages back-to-back until header slots run out
        io.msg_header_ready_and_i = 1'b0;
        run_msg(mk_hdr(4'd3, 3'd3, 40'h00_8000_0400, 16'hE5), 1, 1, 40'h00_8000_0400,
                64'h00, 1'b1, 1'b0, 1'b1, -1, 1'b0, 32'h5555_0000);
        run_msg(mk_hdr(4'd3, 3'd3, 40'h00_8000_0408, 16'hE6), 1, 1, 40'h00_8000_0400,
                64'h08, 1'b1, 1'b0, 1'b1, -1, 1'b0, 32'h5555_0001);
        run_msg(mk_hdr(4'd3, 3'd3, 40'h00_8000_0410, 16'hE7), 1, 1, 40'h00_8000_0400,
                64'h10, 1'b1, 1'b0, 1'b1, 0, 1'b1, 32'h5555_0002);
        idle(4);

        // 6) reset after three beats of an N:N message, then a full message from scratch
        io.msg_header_ready_and_i = 1'b0;
        run_msg(mk_hdr(4'd1, 3'd6, 40'h00_8000_0318, 16'hF6), 8, 3, 40'h00_8000_0300,
                64'h10_08_00_38_30_28_20_18, 1'b1, 1'b1, 1'b0, -1, 1'b0, 32'h6666_0000);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_hdr_v",  128'(io.msg_header_v_o), 128'(0));
        chk("post_rst_data_v", 128'(io.msg_data_v_o),   128'(0));
        chk("post_rst_new",    128'(io.fsm_new_o),      128'(1));
        idle(1);
        io.msg_header_ready_and_i = 1'b1;
        run_msg(mk_hdr(4'd1, 3'd6, 40'h00_8000_0318, 16'hF7), 8, 8, 40'h00_8000_0300,
                64'h10_08_00_38_30_28_20_18, 1'b1, 1'b1, 1'b1, -1, 1'b0, 32'h7777_0000);
        idle(10);

        chk("fsm_q_drained",  128'(q_fsm.size()),  128'(0));
        chk("hdr_q_drained",  128'(q_hdr.size()),  128'(0));
        chk("data_q_drained", 128'(q_data.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
